rand_generator_param: RTL and testbench

Parametrised Fibonacci LFSR random source, the successor to the fixed 24-bit generator. Width, taps, seed, output width and decimation are generic. Two modes: free-running (legacy behaviour, one word per cycle) and request/valid handshake, which delivers DECIM-times-decorrelated words. Feeds the GPU pixel-noise/dither path and any consumer needing on-demand random words.

---
 rtl/rand_generator_param_if.sv | 29 ++
 rtl/rand_generator_param.sv | 182 ++++++++++++++++++
 tb/tb_rand_generator_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rand_generator_param_if.sv
// Handshake and control bundle for rand_generator_param.
// The master side drives enables, seeding, requests and consumer acceptance;
// the slave side (the generator) returns ready, the random word, its valid
// flag and the delivered-word statistic.
interface rand_generator_param_if #(
    parameter int LFSR_W = 24,
    parameter int OUT_W  = 12
);
    logic              en;
    logic              mode;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic              req;
    logic              ready;
    logic [OUT_W-1:0]  rand_num;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       stats_count;

    modport master (
        output en, mode, seed_load, seed_in, req, out_ready,
        input  ready, rand_num, out_valid, stats_count
    );

    modport slave (
        input  en, mode, seed_load, seed_in, req, out_ready,
        output ready, rand_num, out_valid, stats_count
    );
endinterface

// File: rtl/rand_generator_param.sv
// Parametrised Fibonacci LFSR random source.
// Free-run mode (mode=0) produces one word per enabled cycle, lagging the
// LFSR by one shift for compatibility with the older 24-bit generator.
// Request mode (mode=1) runs DECIM shifts per word and holds the result
// until the consumer accepts it.
// Optional build macro RAND_STATS_EN adds a saturating delivered-word
// counter on stats_count; without it stats_count is constant zero.
module rand_generator_param #(
    parameter int          LFSR_W = 24,
    parameter int          OUT_W  = 12,
    parameter logic [31:0] TAPS   = 32'h00E1_0000,
    parameter logic [31:0] SEED   = 32'h0012_3456,
    parameter int          DECIM  = 12
) (
    input logic                  clk,
    input logic                  reset,
    rand_generator_param_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } fsm_t;

    localparam logic [LFSR_W-1:0] SEED_V   = SEED[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] TAP_V    = TAPS[LFSR_W-1:0];
    localparam logic [7:0]        DECIM_M1 = 8'(DECIM - 1);
    localparam logic [LFSR_W-1:0] ZERO_V   = {LFSR_W{1'b0}};

    // One Fibonacci step: parity of the tapped bits enters at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_V)};
    endfunction

    fsm_t              fsm_r;
    fsm_t              fsm_s;
    logic [LFSR_W-1:0] state_r;
    logic [LFSR_W-1:0] state_s;
    logic [LFSR_W-1:0] step_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_s;
    logic [OUT_W-1:0]  rand_r;
    logic [OUT_W-1:0]  rand_s;
    logic              valid_r;
    logic              valid_s;

    assign step_s = lfsr_next(state_r);

    // Next-state logic: seed loading overrides the mode behaviour, and an
    // all-zero state is replaced by the seed rather than shifted.
    always_comb begin
        fsm_s   = fsm_r;
        state_s = state_r;
        cnt_s   = cnt_r;
        rand_s  = rand_r;
        valid_s = valid_r;
        if (bus.seed_load) begin
            state_s = (bus.seed_in == ZERO_V) ? SEED_V : bus.seed_in;
            fsm_s   = IDLE;
            valid_s = 1'b0;
            cnt_s   = 8'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (!bus.mode) begin
                        // Free-run: publish the pre-shift value, legacy lag.
                        if (bus.en) begin
                            state_s = step_s;
                            rand_s  = state_r[OUT_W-1:0];
                            valid_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end else begin
                        valid_s = 1'b0;
                        if (bus.req) begin
                            state_s = step_s;
                            if (DECIM == 32'sd1) begin
                                fsm_s   = HOLD;
                                rand_s  = step_s[OUT_W-1:0];
                                valid_s = 1'b1;
                                cnt_s   = 8'd0;
                            end else begin
                                fsm_s = SHIFT;
                                cnt_s = 8'd1;
                            end
                        end else begin
                            fsm_s = IDLE;
                        end
                    end
                end
                SHIFT: begin
                    state_s = step_s;
                    if (cnt_r == DECIM_M1) begin
                        rand_s  = step_s[OUT_W-1:0];
                        valid_s = 1'b1;
                        fsm_s   = HOLD;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = 8'(cnt_r + 8'd1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (bus.req) begin
                            // Back-to-back word: restart from the frozen state.
                            state_s = step_s;
                            if (DECIM == 32'sd1) begin
                                fsm_s   = HOLD;
                                rand_s  = step_s[OUT_W-1:0];
                                valid_s = 1'b1;
                                cnt_s   = 8'd0;
                            end else begin
                                fsm_s   = SHIFT;
                                valid_s = 1'b0;
                                cnt_s   = 8'd1;
                            end
                        end else begin
                            fsm_s   = IDLE;
                            valid_s = 1'b0;
                        end
                    end else begin
                        fsm_s = HOLD;
                    end
                end
                default: begin
                    fsm_s   = IDLE;
                    valid_s = 1'b0;
                    cnt_s   = 8'd0;
                end
            endcase
            state_s = (state_r == ZERO_V) ? SEED_V : state_s;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r   <= IDLE;
            state_r <= SEED_V;
            cnt_r   <= 8'd0;
            rand_r  <= {OUT_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            fsm_r   <= fsm_s;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rand_r  <= rand_s;
            valid_r <= valid_s;
        end
    end

    assign bus.ready     = (fsm_r == IDLE) && !reset;
    assign bus.rand_num  = rand_r;
    assign bus.out_valid = valid_r;

`ifdef RAND_STATS_EN
    logic [15:0] stats_r;
    logic        deliver_s;

    assign deliver_s = !bus.seed_load &&
                       (((fsm_r == IDLE) && !bus.mode && bus.en) ||
                        ((fsm_r == HOLD) && bus.out_ready));

    // Saturating count of delivered words, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stats_r <= 16'h0000;
        end else if (deliver_s && (stats_r != 16'hFFFF)) begin
            stats_r <= stats_r + 16'h0001;
        end else begin
            stats_r <= stats_r;
        end
    end

    assign bus.stats_count = stats_r;
`else
    assign bus.stats_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rand_generator_param.sv
// Scoreboard bench for rand_generator_param with default parameters.
// Expected words are queued when stimulus is issued; a forked monitor pops
// and compares on every delivered word.
module tb_rand_generator_param;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rand_generator_param_if #(.LFSR_W(24), .OUT_W(12)) bus ();

    rand_generator_param dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q[$];
    bit          free_run = 1'b0;
    logic [23:0] model;
    logic [11:0] held;
    int          lat;
    bit          seen;
    logic [15:0] exp_stats;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference LFSR: taps 23,22,21,16 written out explicitly.
    function automatic logic [23:0] step_n(input logic [23:0] s, input int n);
        logic [23:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.out_valid && (free_run || bus.out_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: got %0h expected no word", bus.rand_num);
                end else begin
                    check("word", {20'd0, bus.rand_num}, {20'd0, exp_q.pop_front()});
                end
            end
        end
    endtask

    // Issue a request (optionally accepting the held word in the same cycle)
    // and count edges until out_valid, bounded.
    task automatic request(input bit chain, output int n);
        bus.req = 1'b1;
        if (chain) bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                bus.req       = 1'b0;
                bus.out_ready = 1'b0;
                if (chain) check("chain_gap", {31'd0, bus.out_valid}, 32'd0);
            end
        end while (!bus.out_valid && n < 200);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        bus.en = 1'b0; bus.mode = 1'b0; bus.seed_load = 1'b0;
        bus.seed_in = 24'h000000; bus.req = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        check("ready_in_reset", {31'd0, bus.ready}, 32'd0);
        tick();
        check("reset_rand", {20'd0, bus.rand_num}, 32'd0);
        check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_stats", {16'd0, bus.stats_count}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_idle", {31'd0, bus.ready}, 32'd1);

        // Free-run, 4 words: pre-shift values of 123456, 2468AC, 48D159, 91A2B3.
        exp_q.push_back(12'h456);
        exp_q.push_back(12'h8AC);
        exp_q.push_back(12'h159);
        exp_q.push_back(12'h2B3);
        free_run = 1'b1;
        bus.en = 1'b1;
        repeat (4) tick();
        bus.en = 1'b0;
        tick();
        free_run = 1'b0;
        check("en_low_valid", {31'd0, bus.out_valid}, 32'd0);
        check("en_low_hold", {20'd0, bus.rand_num}, 32'h2B3);
        model = 24'h234566;

        // Request mode word 1, then hold off acceptance for 5 cycles.
        bus.mode = 1'b1;
        model = step_n(model, 12);
        exp_q.push_back(model[11:0]);
        request(1'b0, lat);
        check("latency1", lat, 32'd12);
        check("ready_hold", {31'd0, bus.ready}, 32'd0);
        held = model[11:0];
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rand", {20'd0, bus.rand_num}, {20'd0, held});
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        accept();
        check("ready_after_accept", {31'd0, bus.ready}, 32'd1);

        // Word 2, then word 3 requested in the same cycle word 2 is accepted.
        model = step_n(model, 12);
        exp_q.push_back(model[11:0]);
        request(1'b0, lat);
        check("latency2", lat, 32'd12);
        model = step_n(model, 12);
        exp_q.push_back(model[11:0]);
        request(1'b1, lat);
        check("latency3", lat, 32'd12);
        accept();
`ifdef RAND_STATS_EN
        exp_stats = 16'd7;
`else
        exp_stats = 16'd0;
`endif
        check("stats", {16'd0, bus.stats_count}, {16'd0, exp_stats});

        // Zero seed falls back to SEED; rand_num holds across the load.
        held = model[11:0];
        bus.seed_in = 24'h000000;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        check("seed0_valid", {31'd0, bus.out_valid}, 32'd0);
        check("seed0_rand_hold", {20'd0, bus.rand_num}, {20'd0, held});
        bus.mode = 1'b0;
        exp_q.push_back(12'h456);
        free_run = 1'b1;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        tick();
        free_run = 1'b0;

        // seed_load in the middle of SHIFT aborts the word.
        bus.mode = 1'b1;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (3) tick();
        bus.seed_in = 24'h00ABCD;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_word", {31'd0, seen}, 32'd0);

        // Word from the loaded seed, then reset while it is held.
        model = step_n(24'h00ABCD, 12);
        request(1'b0, lat);
        check("latency4", lat, 32'd12);
        check("seeded_word", {20'd0, bus.rand_num}, {20'd0, model[11:0]});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("hold_reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold_reset_rand", {20'd0, bus.rand_num}, 32'd0);
        check("hold_reset_stats", {16'd0, bus.stats_count}, 32'd0);
        tick();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
